// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - runtime-programmable integer clock divider with sequencing controller
//
// Purpose: divides clk_in by a ratio that can be changed through a valid/ready
// handshake. A new ratio is applied only at a period boundary, and start/stop
// never truncate a period.
//
// Optional feature macro: DIV_DUTY50_EN (negedge flop gives 50% duty for odd ratios).
//
// Ports:
//   clk_in     - single input clock
//   rst_n      - asynchronous active-low reset
//   en         - level run request
//   cfg_valid  - new-ratio request
//   cfg_n      - requested ratio (W bits, must be >= 2)
//   cfg_ready  - shadow register empty, request can be accepted (registered)
//   cfg_err    - one-cycle pulse after a rejected request (ratio < 2)
//   clk_out    - divided clock
//   tick       - high in the last clk_in cycle of each clk_out period
//   busy       - controller not idle
//   cur_n      - ratio currently in effect
module clk_div_ctrl #(
    parameter int W       = 10,
    parameter int N_RESET = 3
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_n,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         clk_out,
    output logic         tick,
    output logic         busy,
    output logic [W-1:0] cur_n
);

    localparam logic [W-1:0] LP_N_RESET = W'(N_RESET);
    localparam logic [W-1:0] LP_ONE     = W'(1);
    localparam logic [W-1:0] LP_TWO     = W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   r_cur_n;
    logic [W-1:0]   r_shadow;
    logic           r_cfg_ready;
    logic           r_cfg_err;

    logic           w_busy;
    logic           w_wrap;
    logic           w_hi;
    logic           w_accept;
    logic           w_cfg_bad;

    assign w_busy    = (r_state != S_IDLE);
    // Wrap edge: the edge that leaves counter == cur_n-1 while running.
    assign w_wrap    = w_busy && (r_cnt == (r_cur_n - LP_ONE));
    assign w_hi      = w_busy && (r_cnt < (r_cur_n >> 1));
    assign w_accept  = cfg_valid && r_cfg_ready;
    assign w_cfg_bad = (cfg_n < LP_TWO);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cur_n     <= LP_N_RESET;
            r_shadow    <= '0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;

            // Accept and apply are mutually exclusive: accept needs an empty
            // shadow, apply needs a full one. A ratio accepted on a wrap edge
            // is therefore applied only at the following wrap.
            if (w_accept) begin
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                end else begin
                    r_shadow    <= cfg_n;
                    r_cfg_ready <= 1'b0;
                end
            end else if (!r_cfg_ready && (!w_busy || w_wrap)) begin
                r_cur_n     <= r_shadow;
                r_cfg_ready <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_wrap) begin
                        r_cnt <= '0;
                        if (!en) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                        if (!en) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    // Period keeps running; re-enable resumes without a gap.
                    if (w_wrap) begin
                        r_cnt   <= '0;
                        r_state <= en ? S_RUN : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + LP_ONE;
                        if (en) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DIV_DUTY50_EN
    logic r_neg_hi;

    // Half-cycle delayed copy of the high phase for odd ratios; OR-ing it in
    // stretches the high phase by half a clk_in period.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_hi <= 1'b0;
        end else begin
            r_neg_hi <= w_busy && r_cur_n[0] && w_hi;
        end
    end

    assign clk_out = w_hi | r_neg_hi;
`else
    assign clk_out = w_hi;
`endif

    assign tick      = w_wrap;
    assign busy      = w_busy;
    assign cur_n     = r_cur_n;
    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl (default build)
module tb_clk_div_ctrl;

    localparam int W = 10;

    logic         clk_in;
    logic         rst_n;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_n;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;
    logic         busy;
    logic [W-1:0] cur_n;

    int checks;
    int errors;

    clk_div_ctrl #(.W(W), .N_RESET(3)) u_dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_n     (cfg_n),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_n     (cur_n)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic         en;
        logic         cv;
        logic [W-1:0] cn;
        logic         clk;
        logic         tck;
        logic         bsy;
        logic         rdy;
        logic         err;
        logic [W-1:0] cur;
    } vec_t;

    localparam int NV = 41;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic e, input logic cv, input int cn,
                                input logic c, input logic t, input logic b,
                                input logic r, input logic er, input int cu);
        vec_t v;
        v.en = e; v.cv = cv; v.cn = W'(cn);
        v.clk = c; v.tck = t; v.bsy = b; v.rdy = r; v.err = er; v.cur = W'(cu);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic c, input logic t, input logic b,
                           input logic r, input logic er, input logic [W-1:0] cu);
        chk("clk_out",   idx, 32'(clk_out),   32'(c));
        chk("tick",      idx, 32'(tick),      32'(t));
        chk("busy",      idx, 32'(busy),      32'(b));
        chk("cfg_ready", idx, 32'(cfg_ready), 32'(r));
        chk("cfg_err",   idx, 32'(cfg_err),   32'(er));
        chk("cur_n",     idx, 32'(cur_n),     32'(cu));
    endtask

    initial begin
        int highs;
        int ticks;
        int tick_idx;

        checks = 0;
        errors = 0;

        //          en cv cn  | clk tck bsy rdy err cur
        tbl[0]  = mk(1, 0, 0,   1, 0, 1, 1, 0, 3);   // start: cnt0
        tbl[1]  = mk(1, 0, 0,   0, 0, 1, 1, 0, 3);
        tbl[2]  = mk(1, 0, 0,   0, 1, 1, 1, 0, 3);
        tbl[3]  = mk(1, 0, 0,   1, 0, 1, 1, 0, 3);
        tbl[4]  = mk(1, 1, 4,   0, 0, 1, 0, 0, 3);   // accept 4 mid-period
        tbl[5]  = mk(1, 0, 0,   0, 1, 1, 0, 0, 3);
        tbl[6]  = mk(1, 0, 0,   1, 0, 1, 1, 0, 4);   // applied at wrap
        tbl[7]  = mk(1, 0, 0,   1, 0, 1, 1, 0, 4);
        tbl[8]  = mk(1, 0, 0,   0, 0, 1, 1, 0, 4);
        tbl[9]  = mk(1, 0, 0,   0, 1, 1, 1, 0, 4);
        tbl[10] = mk(1, 1, 1,   1, 0, 1, 1, 1, 4);   // reject ratio 1
        tbl[11] = mk(1, 0, 0,   1, 0, 1, 1, 0, 4);
        tbl[12] = mk(1, 0, 0,   0, 0, 1, 1, 0, 4);
        tbl[13] = mk(1, 0, 0,   0, 1, 1, 1, 0, 4);
        tbl[14] = mk(1, 1, 5,   1, 0, 1, 0, 0, 4);   // accept on wrap edge
        tbl[15] = mk(1, 1, 7,   1, 0, 1, 0, 0, 4);   // ignored: shadow full
        tbl[16] = mk(1, 0, 0,   0, 0, 1, 0, 0, 4);
        tbl[17] = mk(1, 0, 0,   0, 1, 1, 0, 0, 4);
        tbl[18] = mk(1, 0, 0,   1, 0, 1, 1, 0, 5);   // applied one wrap later
        tbl[19] = mk(1, 0, 0,   1, 0, 1, 1, 0, 5);
        tbl[20] = mk(0, 0, 0,   0, 0, 1, 1, 0, 5);   // en low at cnt1
        tbl[21] = mk(0, 0, 0,   0, 0, 1, 1, 0, 5);
        tbl[22] = mk(0, 0, 0,   0, 1, 1, 1, 0, 5);
        tbl[23] = mk(0, 0, 0,   0, 0, 0, 1, 0, 5);   // busy falls at wrap
        tbl[24] = mk(0, 0, 0,   0, 0, 0, 1, 0, 5);
        tbl[25] = mk(1, 0, 0,   1, 0, 1, 1, 0, 5);   // restart
        tbl[26] = mk(1, 0, 0,   1, 0, 1, 1, 0, 5);
        tbl[27] = mk(0, 0, 0,   0, 0, 1, 1, 0, 5);   // stop at cnt1
        tbl[28] = mk(0, 0, 0,   0, 0, 1, 1, 0, 5);
        tbl[29] = mk(1, 0, 0,   0, 1, 1, 1, 0, 5);   // en back at cnt3
        tbl[30] = mk(1, 0, 0,   1, 0, 1, 1, 0, 5);   // no gap
        tbl[31] = mk(1, 0, 0,   1, 0, 1, 1, 0, 5);
        tbl[32] = mk(1, 0, 0,   0, 0, 1, 1, 0, 5);
        tbl[33] = mk(1, 0, 0,   0, 0, 1, 1, 0, 5);
        tbl[34] = mk(1, 0, 0,   0, 1, 1, 1, 0, 5);
        tbl[35] = mk(0, 0, 0,   0, 0, 0, 1, 0, 5);   // wrap + en fall -> IDLE
        tbl[36] = mk(0, 1, 2,   0, 0, 0, 0, 0, 5);   // accept in IDLE
        tbl[37] = mk(0, 0, 0,   0, 0, 0, 1, 0, 2);   // applied next edge
        tbl[38] = mk(1, 0, 0,   1, 0, 1, 1, 0, 2);
        tbl[39] = mk(1, 0, 0,   0, 1, 1, 1, 0, 2);
        tbl[40] = mk(1, 0, 0,   1, 0, 1, 1, 0, 2);

        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_n     = '0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(3));
        rst_n = 1'b1;
        step();
        chk_all(-2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(3));

        for (int i = 0; i < NV; i++) begin
            en        = tbl[i].en;
            cfg_valid = tbl[i].cv;
            cfg_n     = tbl[i].cn;
            step();
            chk_all(i, tbl[i].clk, tbl[i].tck, tbl[i].bsy, tbl[i].rdy, tbl[i].err, tbl[i].cur);
        end
        cfg_valid = 1'b0;

        // Reset mid-period with a ratio pending.
        cfg_valid = 1'b1;
        cfg_n     = W'(6);
        step();
        cfg_valid = 1'b0;
        chk("pend_ready", 100, 32'(cfg_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(3));
        en = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        step();
        chk_all(102, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(3));

        // Maximum ratio 1023.
        cfg_valid = 1'b1;
        cfg_n     = W'(1023);
        step();
        cfg_valid = 1'b0;
        step();
        chk("max_cur_n", 103, 32'(cur_n), 32'd1023);
        chk("max_ready", 103, 32'(cfg_ready), 32'd1);
        en = 1'b1;
        step();
        highs    = 0;
        ticks    = 0;
        tick_idx = -1;
        for (int i = 0; i < 1023; i++) begin
            if (clk_out) highs++;
            if (tick) begin
                ticks++;
                tick_idx = i;
            end
            step();
        end
        chk("max_highs",    104, 32'(highs),    32'd511);
        chk("max_ticks",    104, 32'(ticks),    32'd1);
        chk("max_tick_idx", 104, 32'(tick_idx), 32'd1022);
        chk("max_restart",  104, 32'(clk_out),  32'd1);
        chk("max_tick0",    104, 32'(tick),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
